// File: rtl/systolic_input_feeder_if.sv
// Write-side vector handshake into the systolic input feeder.
// Upstream drives a full N-lane vector per valid/ready transfer.
interface systolic_input_feeder_if #(
    parameter int N = 4
);
    logic               wr_valid;
    logic [N-1:0][31:0] wr_data;
    logic               wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/systolic_input_feeder.sv
// Edge feeder for the systolic array: per-lane FIFOs drained with a one-cycle diagonal skew.
// Defining FEEDER_FLUSH_EN adds the synchronous flush_i port.
module systolic_input_feeder #(
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    systolic_input_feeder_if.slave wr,
    output logic [N-1:0][31:0]     x_o,
    output logic [N-1:0]           start_o,
    input  logic [N-1:0]           stall_i,
`ifdef FEEDER_FLUSH_EN
    input  logic                   flush_i,
`endif
    output logic                   busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(DEPTH + 1) + 1;

    logic [N-1:0][CW-1:0] count_q, count_d;
    logic [N-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [N-1:0][TW-1:0] token_q, token_d;
    logic [N-1:0][31:0]   x_q, x_d;
    logic [N-1:0]         start_q, start_d;
    logic [N-1:0]         load;
    logic [N-1:0]         room;
    logic [N-1:0]         nonempty;
    logic [31:0]          mem_q [N][DEPTH];
    logic                 flush;
    logic                 ready;
    logic                 accept;

`ifdef FEEDER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // A lane loads only when it holds data, has a skew token from the lane
    // above, and its output register is empty or being taken this cycle.
    always_comb begin
        room     = '0;
        nonempty = '0;
        load     = '0;
        for (int k = 0; k < N; k++) begin
            room[k]     = (count_q[k] < CW'(DEPTH));
            nonempty[k] = (count_q[k] != '0);
            load[k]     = nonempty[k]
                          && ((k == 0) || (token_q[k] != '0))
                          && (!start_q[k] || !stall_i[k])
                          && !flush;
        end
    end

    assign ready       = (&room) && !flush;
    assign wr.wr_ready = ready;
    assign accept      = wr.wr_valid && ready;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        token_d  = token_q;
        x_d      = x_q;
        start_d  = start_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        for (int k = 0; k < N; k++) begin
            case ({accept, load[k]})
                2'b10:   count_d[k] = count_q[k] + CW'(1);
                2'b01:   count_d[k] = count_q[k] - CW'(1);
                default: count_d[k] = count_q[k];
            endcase

            if (load[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
                x_d[k]      = mem_q[k][rd_ptr_q[k]];
                start_d[k]  = 1'b1;
            end else if (start_q[k] && !stall_i[k]) begin
                start_d[k] = 1'b0;
            end
        end

        // Lane k earns a token for every load above it and spends one per own load.
        for (int k = 1; k < N; k++) begin
            case ({load[k-1], load[k]})
                2'b10:   token_d[k] = token_q[k] + TW'(1);
                2'b01:   token_d[k] = token_q[k] - TW'(1);
                default: token_d[k] = token_q[k];
            endcase
        end

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            token_d  = '0;
            start_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            token_q  <= '0;
            x_q      <= '0;
            start_q  <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            token_q  <= token_d;
            x_q      <= x_d;
            start_q  <= start_d;
        end
    end

    // Storage is not reset; the cleared counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N; k++) begin
                mem_q[k][wr_ptr_q] <= wr.wr_data[k];
            end
        end
    end

    assign x_o     = x_q;
    assign start_o = start_q;
    assign busy    = (|nonempty) || (|start_q);
endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder: vector table for the basic skew plus hand sequences.
// Builds with or without FEEDER_FLUSH_EN.
module tb_systolic_input_feeder;
    localparam int N     = 4;
    localparam int DEPTH = 8;

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;

    logic               clk = 1'b0;
    logic               n_rst;
    logic [N-1:0]       stall_i;
    logic [N-1:0][31:0] x_o;
    logic [N-1:0]       start_o;
    logic               busy;
`ifdef FEEDER_FLUSH_EN
    logic               flush_i;
`endif

    int errors  = 0;
    int checks  = 0;
    int acc_cnt = 0;
    logic [31:0] exp_q [N][$];

    typedef struct {
        logic               valid;
        logic [N-1:0][31:0] data;
        logic [N-1:0]       stall;
        logic               exp_ready;
        logic [N-1:0]       exp_start;
        logic               exp_busy;
        logic [N-1:0][31:0] exp_x;
    } vec_t;

    vec_t tbl [6];

    systolic_input_feeder_if #(.N(N)) wr_if ();

    systolic_input_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr      (wr_if),
        .x_o     (x_o),
        .start_o (start_o),
        .stall_i (stall_i),
`ifdef FEEDER_FLUSH_EN
        .flush_i (flush_i),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0][31:0] mk(input int i);
        logic [N-1:0][31:0] r;
        for (int k = 0; k < N; k++) r[k] = 32'((k + 1) * 32'h1000_0000 + i);
        return r;
    endfunction

    // Scoreboard: record accepted vectors per lane, compare every PE transfer in order.
    task automatic monitor();
        if (wr_if.wr_valid && wr_if.wr_ready) begin
            acc_cnt++;
            for (int k = 0; k < N; k++) exp_q[k].push_back(wr_if.wr_data[k]);
        end
        for (int k = 0; k < N; k++) begin
            if (start_o[k] && !stall_i[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lane%0d unexpected transfer: got %0h expected none", k, x_o[k]);
                end else begin
                    check($sformatf("lane%0d order", k), 128'(x_o[k]), 128'(exp_q[k].pop_front()));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) exp_q[k].delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        wr_if.wr_valid = 1'b0;
        stall_i        = '0;
        while ((busy || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
                exp_q[2].size() != 0 || exp_q[3].size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check({name, " idle"}, 128'(busy), 128'(0));
        for (int k = 0; k < N; k++)
            check($sformatf("%s lane%0d left", name, k), 128'(exp_q[k].size()), 128'(0));
    endtask

    initial begin
        logic [N-1:0][31:0] v;
        logic [N-1:0][31:0] xsave;
        int base;

        n_rst          = 1'b0;
        stall_i        = '0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
`ifdef FEEDER_FLUSH_EN
        flush_i        = 1'b0;
`endif
        v = {F4, F3, F2, F1};
        tbl[0] = '{1'b1, v,      4'b0, 1'b1, 4'b0000, 1'b1, 128'h0};
        tbl[1] = '{1'b0, 128'h0, 4'b0, 1'b1, 4'b0001, 1'b1, {96'h0, F1}};
        tbl[2] = '{1'b0, 128'h0, 4'b0, 1'b1, 4'b0010, 1'b1, {64'h0, F2, F1}};
        tbl[3] = '{1'b0, 128'h0, 4'b0, 1'b1, 4'b0100, 1'b1, {32'h0, F3, F2, F1}};
        tbl[4] = '{1'b0, 128'h0, 4'b0, 1'b1, 4'b1000, 1'b1, v};
        tbl[5] = '{1'b0, 128'h0, 4'b0, 1'b1, 4'b0000, 1'b0, v};

        #12;
        check("reset x_o", x_o, 128'h0);
        check("reset start_o", 128'(start_o), 128'h0);
        check("reset wr_ready", 128'(wr_if.wr_ready), 128'(1));
        check("reset busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Basic skew: one vector, lane k loads at edge 1+k.
        for (int i = 0; i < 6; i++) begin
            wr_if.wr_valid = tbl[i].valid;
            wr_if.wr_data  = tbl[i].data;
            stall_i        = tbl[i].stall;
            tick();
            check($sformatf("t1 row%0d ready", i), 128'(wr_if.wr_ready), 128'(tbl[i].exp_ready));
            check($sformatf("t1 row%0d start", i), 128'(start_o), 128'(tbl[i].exp_start));
            check($sformatf("t1 row%0d busy", i), 128'(busy), 128'(tbl[i].exp_busy));
            check($sformatf("t1 row%0d x", i), x_o, tbl[i].exp_x);
        end
        drain("t1");

        // Lane 1 stalled for five edges during a three-vector stream.
        for (int i = 0; i < 3; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = mk(10 + i);
            stall_i        = '0;
            tick();
        end
        wr_if.wr_valid = 1'b0;
        stall_i        = 4'b0010;
        tick();
        tick();
        v = mk(10);
        check("t2 start after E4", 128'(start_o), 128'(4'b1010));
        check("t2 x3 after E4", 128'(x_o[3]), 128'(v[3]));
        tick();
        check("t2 start after E5", 128'(start_o), 128'(4'b0010));
        check("t2 x1 held E5", 128'(x_o[1]), 128'(v[1]));
        tick();
        tick();
        check("t2 start after E7", 128'(start_o), 128'(4'b0010));
        check("t2 x1 held E7", 128'(x_o[1]), 128'(v[1]));
        check("t2 busy during stall", 128'(busy), 128'(1));
        stall_i = '0;
        drain("t2");

        // Fill: output registers occupied, then eight more vectors fill every FIFO.
        base           = acc_cnt;
        stall_i        = '1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = mk(30);
        tick();
        wr_if.wr_valid = 1'b0;
        repeat (4) tick();
        check("t3 all outputs loaded", 128'(start_o), 128'(4'b1111));
        for (int i = 0; i < 8; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = mk(31 + i);
            tick();
            if (i == 6) check("t3 ready after 7th", 128'(wr_if.wr_ready), 128'(1));
        end
        check("t3 ready after 8th", 128'(wr_if.wr_ready), 128'(0));
        wr_if.wr_data = mk(39);
        tick();
        check("t3 ready while stalled", 128'(wr_if.wr_ready), 128'(0));
        stall_i = '0;
        tick();
        check("t3 ready lane1-3 full", 128'(wr_if.wr_ready), 128'(0));
        tick();
        check("t3 ready lane2-3 full", 128'(wr_if.wr_ready), 128'(0));
        tick();
        check("t3 ready lane3 full", 128'(wr_if.wr_ready), 128'(0));
        tick();
        check("t3 ready after drain", 128'(wr_if.wr_ready), 128'(1));
        tick();
        check("t3 accept count", 128'(acc_cnt - base), 128'(10));
        drain("t3");

        // Back-to-back stream of 20 vectors.
        base    = acc_cnt;
        stall_i = '0;
        for (int i = 0; i < 20; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = mk(100 + i);
            tick();
        end
        wr_if.wr_valid = 1'b0;
        check("t4 accept count", 128'(acc_cnt - base), 128'(20));
        drain("t4");

        // Asynchronous reset with four vectors buffered.
        stall_i = '1;
        for (int i = 0; i < 4; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = mk(200 + i);
            tick();
        end
        wr_if.wr_valid = 1'b0;
        check("t5 busy before reset", 128'(busy), 128'(1));
        #2;
        n_rst = 1'b0;
        #1;
        check("t5 reset x_o", x_o, 128'h0);
        check("t5 reset start_o", 128'(start_o), 128'h0);
        check("t5 reset wr_ready", 128'(wr_if.wr_ready), 128'(1));
        check("t5 reset busy", 128'(busy), 128'(0));
        clear_model();
        @(posedge clk);
        #1;
        n_rst   = 1'b1;
        stall_i = '0;
        repeat (8) tick();
        check("t5 start after release", 128'(start_o), 128'h0);
        check("t5 busy after release", 128'(busy), 128'(0));

`ifdef FEEDER_FLUSH_EN
        // Flush with data buffered and a vector offered in the same cycle.
        stall_i = '1;
        for (int i = 0; i < 3; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = mk(300 + i);
            tick();
        end
        wr_if.wr_valid = 1'b0;
        tick();
        xsave          = x_o;
        base           = acc_cnt;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = mk(399);
        flush_i        = 1'b1;
        @(negedge clk);
        check("t6 ready during flush", 128'(wr_if.wr_ready), 128'(0));
        monitor();
        @(posedge clk);
        #1;
        flush_i        = 1'b0;
        wr_if.wr_valid = 1'b0;
        check("t6 busy after flush", 128'(busy), 128'(0));
        check("t6 start after flush", 128'(start_o), 128'h0);
        check("t6 x_o held", x_o, xsave);
        check("t6 ready after flush", 128'(wr_if.wr_ready), 128'(1));
        check("t6 nothing accepted", 128'(acc_cnt - base), 128'(0));
        clear_model();
        stall_i = '0;
        repeat (6) tick();
        check("t6 busy stays low", 128'(busy), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_input_feeder.md
# systolic_input_feeder

Upstream feeder for one edge of the systolic array: accepts one N-lane vector of fp32 operands per handshake, buffers each lane in a private FIFO, and drives the `x_i`/`input_start` inputs of the N edge processing elements with a one-cycle-per-lane diagonal skew. Lane k never runs ahead of lane k-1. Each lane honours the `stall` output of the processing element it feeds.

## Interface
- `N`, 4: lane count; equals the array edge length.
- `DEPTH`, 8: entries per lane FIFO; a power of two, at least 2.
- `clk`  in  1: clock.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `wr_valid`  in  1: upstream vector valid.
- `wr_data`  in  N×32 (word_t[N]): vector; element k goes to lane k.
- `wr_ready`  out  1: the feeder can accept a vector.
- `x_o`  out  N×32 (word_t[N]): operand to PE row k.
- `start_o`  out  N: `input_start` to PE row k.
- `stall_i`  in  N: `stall` from PE row k.
- `busy`  out  1: any FIFO is non-empty or any `start_o` is high.
- `flush_i`  in  1: synchronous flush. Present only with `FEEDER_FLUSH_EN`.

## Operation
- Accept: a vector is accepted on the edge where `wr_valid && wr_ready`. All N elements are written to their lane FIFOs together.
- `wr_ready` = every lane count < DEPTH. It is combinational from the registered counts. There is no full-bypass: a pop in the same cycle does not make room for a write.
- Per-lane output register (`x_o[k]`, `start_o[k]`):
  - Transfer to the PE happens on an edge where `start_o[k] && !stall_i[k]`.
  - Load condition: FIFO[k] non-empty, token[k] > 0 (lane 0 needs no token), and `!start_o[k] || !stall_i[k]`. On load, the FIFO head is popped into `x_o[k]` and `start_o[k]` is set to 1.
  - Transfer with no load: `start_o[k]` goes to 0 and `x_o[k]` holds its value.
  - `start_o[k]` high with `stall_i[k]` high: the lane holds everything.
- Skew tokens:
  - token[k], for k ≥ 1, increments on each lane k-1 load and decrements on each lane k load.
  - A simultaneous increment and decrement leaves the token unchanged.
  - Width is clog2(DEPTH+1)+1. The token can never exceed count[k], so it cannot overflow.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- A write to an empty FIFO is visible to the load logic on the following cycle. There is no write-to-output bypass.

## Timing
- Reset values:
  - `x_o` = 0, `start_o` = 0.
  - All counts, pointers and tokens = 0.
  - `wr_ready` = 1, `busy` = 0.
- Latency, no stalls: for a vector accepted at edge E0, lane k loads at edge E(1+k). `start_o[k]` is high during the cycle after E(1+k).
- Throughput: one vector per cycle per lane when `stall_i` is low.
- Reset mid-operation: all buffered data is lost immediately, and the outputs return to their reset values asynchronously.
- Order: elements leave each lane in acceptance order, with no reordering or duplication.

## Configuration
- `FEEDER_FLUSH_EN` defined:
  - The `flush_i` port exists.
  - When `flush_i` is high at an edge, all FIFOs, tokens and `start_o` are cleared. `x_o` holds its value.
  - Flush has priority over accept and load in the same cycle, and the accepted vector is discarded.
  - `wr_ready` is forced to 0 during the flush cycle.
- Undefined: there is no `flush_i` port, and only `n_rst` clears state.

## Test plan
- Reset, then accept vector {1.0, 2.0, 3.0, 4.0} at E0 with `stall_i` = 0 → `start_o[k]` is high only in the cycle after E(1+k), with `x_o[k]` = 1.0, 2.0, 3.0, 4.0 respectively; then `busy` drops to 0.
- Hold `stall_i[1]` = 1 for 5 cycles during a 3-vector stream → lane 1 holds `x_o[1]` and `start_o[1]`. Lanes 2 and 3 stop loading once their tokens run out, while lane 0 continues. All lanes deliver the elements in order once the stall is released.
- Stall all lanes and write 8 vectors (DEPTH = 8) → `wr_ready` = 0 after the 8th accept. A 9th `wr_valid` is not accepted until one lane-0 transfer plus FIFO drain frees a slot in every lane.
- Continuous `wr_valid` for 20 vectors with `stall_i` = 0 → one accept per cycle, and every lane's output sequence equals its input column.
- Assert `n_rst` while 4 vectors are buffered → `x_o` = 0, `start_o` = 0, `wr_ready` = 1 and `busy` = 0 immediately, and nothing is emitted after release.
- With `FEEDER_FLUSH_EN`, pulse `flush_i` with 3 vectors buffered and `wr_valid` high → nothing is accepted or emitted, all counts are 0 next cycle, and `busy` = 0.
